// File: rtl/alu_operand_bypass.sv
// ID/EX operand register with M/W forwarding, load-use stall detection and flush handling.
// Optional DECODE_BYPASS_EN: capture the W-stage result into E when a read-before-write register file is used.
module alu_operand_bypass #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int NUM_SRC = 3,
  parameter int PC_ADDR = 15
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_SRC*ADDR_W-1:0] RAD,
  input  logic [NUM_SRC-1:0]        UseD,
  input  logic [NUM_SRC*DATA_W-1:0] RDD,
  input  logic [DATA_W-1:0]         ExtImmD,
  input  logic                      ALUSrcD,
  input  logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic                      MemtoRegD,
  input  logic [ADDR_W-1:0]         WA3D,
  input  logic                      FlushE,
  input  logic [ADDR_W-1:0]         WA3M,
  input  logic                      RegWriteM,
  input  logic [DATA_W-1:0]         ALUResultM,
  input  logic [ADDR_W-1:0]         WA3W,
  input  logic                      RegWriteW,
  input  logic [DATA_W-1:0]         ResultW,
  output logic                      StallD,
  output logic [NUM_SRC*DATA_W-1:0] SrcE,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic                      MemtoRegE,
  output logic [ADDR_W-1:0]         WA3E
);

  localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(PC_ADDR);

  logic [NUM_SRC*ADDR_W-1:0] raE;
  logic [NUM_SRC-1:0]        useE;
  logic [NUM_SRC*DATA_W-1:0] rdE;
  logic [NUM_SRC*DATA_W-1:0] rdCapture;
  logic [DATA_W-1:0]         extImmE;
  logic                      aluSrcE;
  logic                      loadUseHit;
  logic                      bubble;
  logic [NUM_SRC-1:0]        hitM;
  logic [NUM_SRC-1:0]        hitW;

  // Load-use detection: a load in E whose destination a real D-stage source reads.
  always_comb begin
    loadUseHit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      loadUseHit = loadUseHit | (UseD[i] & ValidD
                   & (RAD[i*ADDR_W +: ADDR_W] == WA3E)
                   & (RAD[i*ADDR_W +: ADDR_W] != PC_REG));
    end
    StallD = ValidE & RegWriteE & MemtoRegE & loadUseHit;
    bubble = StallD | FlushE;
  end

  // Register data captured into E; optionally takes the W result being written this cycle.
  always_comb begin
    rdCapture = RDD;
`ifdef DECODE_BYPASS_EN
    for (int i = 0; i < NUM_SRC; i++) begin
      rdCapture[i*DATA_W +: DATA_W] = (RegWriteW
                                       && (WA3W == RAD[i*ADDR_W +: ADDR_W])
                                       && (RAD[i*ADDR_W +: ADDR_W] != PC_REG))
                                      ? ResultW : RDD[i*DATA_W +: DATA_W];
    end
`endif
  end

  // ID/EX pipeline register; a bubble clears only the control fields.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raE       <= '0;
      useE      <= '0;
      rdE       <= '0;
      extImmE   <= '0;
      aluSrcE   <= 1'b0;
      WA3E      <= '0;
      ValidE    <= 1'b0;
      RegWriteE <= 1'b0;
      MemtoRegE <= 1'b0;
    end else begin
      raE       <= RAD;
      useE      <= UseD;
      rdE       <= rdCapture;
      extImmE   <= ExtImmD;
      aluSrcE   <= ALUSrcD;
      WA3E      <= WA3D;
      ValidE    <= ValidD & ~bubble;
      RegWriteE <= RegWriteD & ~bubble;
      MemtoRegE <= MemtoRegD & ~bubble;
    end
  end

  // Operand selection: M beats W (youngest producer), PC never forwarded, port 1 may take the immediate.
  always_comb begin
    SrcE = '0;
    hitM = '0;
    hitW = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hitM[i] = ValidE & useE[i] & RegWriteM
                & (WA3M == raE[i*ADDR_W +: ADDR_W])
                & (raE[i*ADDR_W +: ADDR_W] != PC_REG);
      hitW[i] = ValidE & useE[i] & RegWriteW
                & (WA3W == raE[i*ADDR_W +: ADDR_W])
                & (raE[i*ADDR_W +: ADDR_W] != PC_REG);
      SrcE[i*DATA_W +: DATA_W] = ((i == 32'sd1) && aluSrcE) ? extImmE
                               : hitM[i] ? ALUResultM
                               : hitW[i] ? ResultW
                               : rdE[i*DATA_W +: DATA_W];
    end
  end

endmodule
